// File: rtl/pingpong_pkg.sv
// Shared types for the ping-pong buffer sequencer.
//   mem_mode_e : 2-bit code consumed by the memory enable decoder
//   state_e    : sequencer states
package pingpong_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,  // all blocks disabled
    MODE_FILL = 2'b01,  // deserializer -> block1 only
    MODE_PING = 2'b10,  // deserializer -> block2, block1 -> serializer
    MODE_PONG = 2'b11   // deserializer -> block1, block2 -> serializer
  } mem_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PING  = 3'd2,
    ST_PONG  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/pingpong_mem_ctrl_blk_counter.sv
// Saturating 0..limit block counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : clear to 0 (wins over inc)
//   inc        : advance by one while below limit
//   limit      : terminal count
//   cnt        : current count (registered)
//   done_c     : cnt has reached limit (combinational)
module blk_counter #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         done_c
);

  assign done_c = (cnt >= limit);

  // Count register; increments are ignored once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !done_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pingpong_mem_ctrl.sv
// Ping-pong buffer sequencer between deserializer and serializer.
//   clk, rst_n   : clock, async active-low reset
//   start, stop  : stream control pulses
//   deser_valid / deser_ready : write-side handshake (deser_ready from state)
//   ser_ready / ser_valid     : read-side handshake (ser_valid = rd_en + 1 cycle)
//   mem_mode     : block-role code for the enable decoder (registered)
//   wr_en, rd_en : memory strobes (combinational from registered state)
//   wr_addr, rd_addr : block addresses (counter bits, registered)
//   busy         : not idle (registered)
module pingpong_mem_ctrl
  import pingpong_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              deser_valid,
  output logic              deser_ready,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic [1:0]        mem_mode,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_e           state_q;
  mem_mode_e        mode_q;
  logic             busy_q;
  logic             ser_valid_q;
  logic             stop_pend_q;
  logic [CNT_W-1:0] last_len_q;

  state_e           next_state_c;
  mem_mode_e        next_mode_c;
  logic             move_c;
  logic             writing_c;
  logic             reading_c;
  logic [CNT_W-1:0] rd_len_c;

  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             wr_done_c;
  logic             rd_done_c;

  assign writing_c = (state_q == ST_FILL) || (state_q == ST_PING) || (state_q == ST_PONG);
  assign reading_c = (state_q == ST_PING) || (state_q == ST_PONG) || (state_q == ST_DRAIN);
  assign rd_len_c  = (state_q == ST_DRAIN) ? last_len_q : DEPTH_CNT;

  assign deser_ready = writing_c && !wr_done_c && !stop_pend_q;
  assign wr_en       = deser_valid && deser_ready;
  assign rd_en       = ser_ready && reading_c && !rd_done_c;

  assign wr_addr   = wr_cnt[ADDR_W-1:0];
  assign rd_addr   = rd_cnt[ADDR_W-1:0];
  assign mem_mode  = mode_q;
  assign busy      = busy_q;
  assign ser_valid = ser_valid_q;

  // Write-side counter; cleared on every state change.
  blk_counter #(.W(CNT_W)) u_wr_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (move_c),
    .inc    (wr_en),
    .limit  (DEPTH_CNT),
    .cnt    (wr_cnt),
    .done_c (wr_done_c)
  );

  // Read-side counter; limit shrinks to the partial length in DRAIN.
  blk_counter #(.W(CNT_W)) u_rd_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (move_c),
    .inc    (rd_en),
    .limit  (rd_len_c),
    .cnt    (rd_cnt),
    .done_c (rd_done_c)
  );

  // Transition decode. A pending stop overrides the normal swap: once the
  // read side is done the just-written block is drained (or skipped if empty).
  always_comb begin
    next_state_c = state_q;
    next_mode_c  = mode_q;
    move_c       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          next_state_c = ST_FILL;
          next_mode_c  = MODE_FILL;
          move_c       = 1'b1;
        end
      end
      ST_FILL: begin
        if (stop_pend_q) begin
          move_c       = 1'b1;
          next_state_c = (wr_cnt == CNT_W'(0)) ? ST_IDLE : ST_DRAIN;
          next_mode_c  = (wr_cnt == CNT_W'(0)) ? MODE_IDLE : MODE_PING;
        end else if (wr_done_c) begin
          move_c       = 1'b1;
          next_state_c = ST_PING;
          next_mode_c  = MODE_PING;
        end
      end
      ST_PING: begin
        if (stop_pend_q) begin
          if (rd_done_c) begin
            move_c       = 1'b1;
            next_state_c = (wr_cnt == CNT_W'(0)) ? ST_IDLE : ST_DRAIN;
            next_mode_c  = (wr_cnt == CNT_W'(0)) ? MODE_IDLE : MODE_PONG;
          end
        end else if (wr_done_c && rd_done_c) begin
          move_c       = 1'b1;
          next_state_c = ST_PONG;
          next_mode_c  = MODE_PONG;
        end
      end
      ST_PONG: begin
        if (stop_pend_q) begin
          if (rd_done_c) begin
            move_c       = 1'b1;
            next_state_c = (wr_cnt == CNT_W'(0)) ? ST_IDLE : ST_DRAIN;
            next_mode_c  = (wr_cnt == CNT_W'(0)) ? MODE_IDLE : MODE_PING;
          end
        end else if (wr_done_c && rd_done_c) begin
          move_c       = 1'b1;
          next_state_c = ST_PING;
          next_mode_c  = MODE_PING;
        end
      end
      ST_DRAIN: begin
        if (rd_done_c) begin
          move_c       = 1'b1;
          next_state_c = ST_IDLE;
          next_mode_c  = MODE_IDLE;
        end
      end
      default: begin
        move_c       = 1'b1;
        next_state_c = ST_IDLE;
        next_mode_c  = MODE_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_IDLE;
      busy_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      stop_pend_q <= 1'b0;
      last_len_q  <= '0;
    end else begin
      state_q     <= next_state_c;
      mode_q      <= next_mode_c;
      busy_q      <= (next_state_c != ST_IDLE);
      ser_valid_q <= rd_en;
      // Write counter is frozen while stop is pending, so it is the partial length.
      if (next_state_c == ST_IDLE) begin
        last_len_q <= '0;
      end else if (move_c && (next_state_c == ST_DRAIN)) begin
        last_len_q <= wr_cnt;
      end
      // stop is ignored in IDLE, including when it coincides with start.
      if (next_state_c == ST_IDLE) begin
        stop_pend_q <= 1'b0;
      end else if (stop && (state_q != ST_IDLE)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_mem_ctrl.sv
// Self-checking bench for pingpong_mem_ctrl (DEPTH=4): block-role model,
// directed literal checks, then randomized traffic with async resets.
module tb_pingpong_mem_ctrl;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              deser_valid = 1'b0;
  logic              deser_ready;
  logic              ser_ready = 1'b0;
  logic              ser_valid;
  logic [1:0]        mem_mode;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;

  int checks = 0;
  int failures = 0;

  pingpong_mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .deser_valid (deser_valid),
    .deser_ready (deser_ready),
    .ser_ready   (ser_ready),
    .ser_valid   (ser_valid),
    .mem_mode    (mem_mode),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which block is being written (0 none, 1, 2) and which is read.
  int m_wblk = 0, m_rblk = 0, m_wc = 0, m_rc = 0, m_last = 0;
  bit m_pend = 1'b0, m_sv = 1'b0;

  function automatic int exp_mode();
    if (m_rblk == 0) return (m_wblk != 0) ? 1 : 0;
    return (m_rblk == 1) ? 2 : 3;
  endfunction

  function automatic bit exp_ready();
    return (m_wblk != 0) && (m_wc < DEPTH) && !m_pend;
  endfunction

  function automatic bit exp_rd();
    int len;
    len = (m_wblk == 0) ? m_last : DEPTH;
    return ser_ready && (m_rblk != 0) && (m_rc < len);
  endfunction

  // Model update on each clock edge or asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    bit e_wr, e_rd, go_idle, moved;
    if (!rst_n) begin
      m_wblk = 0; m_rblk = 0; m_wc = 0; m_rc = 0; m_last = 0;
      m_pend = 1'b0; m_sv = 1'b0;
    end else begin
      e_wr = deser_valid && exp_ready();
      e_rd = exp_rd();
      go_idle = 1'b0;
      moved = 1'b0;
      if (m_wblk == 0 && m_rblk == 0) begin
        if (start) begin
          m_wblk = 1; m_wc = 0; m_rc = 0;
        end
      end else begin
        if (m_wblk == 0) begin
          if (m_rc == m_last) go_idle = 1'b1;
        end else if (m_pend && (m_rblk == 0 || m_rc == DEPTH)) begin
          if (m_wc == 0) go_idle = 1'b1;
          else begin
            m_last = m_wc; m_rblk = m_wblk; m_wblk = 0; moved = 1'b1;
          end
        end else if (!m_pend && m_wc == DEPTH && (m_rblk == 0 || m_rc == DEPTH)) begin
          m_rblk = m_wblk; m_wblk = 3 - m_wblk; moved = 1'b1;
        end
        if (go_idle) begin
          m_wblk = 0; m_rblk = 0; m_wc = 0; m_rc = 0; m_last = 0; m_pend = 1'b0;
        end else if (moved) begin
          m_wc = 0; m_rc = 0; m_pend = m_pend | stop;
        end else begin
          m_wc += int'(e_wr); m_rc += int'(e_rd); m_pend = m_pend | stop;
        end
      end
      m_sv = e_rd;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mode",        int'(mem_mode),    exp_mode());
    check("busy",        int'(busy),        int'((m_wblk | m_rblk) != 0));
    check("deser_ready", int'(deser_ready), int'(exp_ready()));
    check("wr_en",       int'(wr_en),       int'(deser_valid && exp_ready()));
    check("rd_en",       int'(rd_en),       int'(exp_rd()));
    check("wr_addr",     int'(wr_addr),     m_wc % DEPTH);
    check("rd_addr",     int'(rd_addr),     m_rc % DEPTH);
    check("ser_valid",   int'(ser_valid),   int'(m_sv));
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},  int'(mem_mode),    0);
    check({tag, "_busy"},  int'(busy),        0);
    check({tag, "_rdy"},   int'(deser_ready), 0);
    check({tag, "_wr"},    int'(wr_en),       0);
    check({tag, "_rd"},    int'(rd_en),       0);
    check({tag, "_sv"},    int'(ser_valid),   0);
    check({tag, "_waddr"}, int'(wr_addr),     0);
    check({tag, "_raddr"}, int'(rd_addr),     0);
  endtask

  initial begin
    deser_valid = 1'b1;
    ser_ready   = 1'b1;
    @(negedge clk);
    check_reset_vals("in_reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle with no start: nothing moves even with both sides ready.
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("idle");
    end

    // Fill, steady ping-pong, then stop coinciding with the 2nd PING write.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      stop = (c == 16);
      @(negedge clk);
      if (c < 4) begin
        check("fill_wr", int'(wr_en), 1);
        check("fill_addr", int'(wr_addr), c);
        check("fill_mode", int'(mem_mode), 1);
      end
      if (c == 4) begin
        check("bubble1_wr", int'(wr_en), 0);
        check("bubble1_rd", int'(rd_en), 0);
        check("bubble1_mode", int'(mem_mode), 1);
      end
      if (c >= 5 && c <= 8) begin
        check("ping_mode", int'(mem_mode), 2);
        check("ping_rd", int'(rd_en), 1);
        check("ping_raddr", int'(rd_addr), c - 5);
      end
      if (c == 5) check("sv_lag0", int'(ser_valid), 0);
      if (c == 6) check("sv_lag1", int'(ser_valid), 1);
      if (c == 9) begin
        check("bubble2_wr", int'(wr_en), 0);
        check("bubble2_rd", int'(rd_en), 0);
      end
      if (c == 10) check("pong_mode", int'(mem_mode), 3);
      if (c == 15) check("ping2_mode", int'(mem_mode), 2);
      if (c == 17) check("stop_ready", int'(deser_ready), 0);
      if (c == 19) check("stop_lastrd", int'(rd_en), 0);
      if (c == 20) begin
        check("drain_mode", int'(mem_mode), 3);
        check("drain_a0", int'(rd_addr), 0);
        check("drain_rd0", int'(rd_en), 1);
      end
      if (c == 21) check("drain_a1", int'(rd_addr), 1);
      if (c == 22) begin
        check("drain_end_rd", int'(rd_en), 0);
        check("drain_busy", int'(busy), 1);
      end
      if (c == 23) begin
        check("end_busy", int'(busy), 0);
        check("end_mode", int'(mem_mode), 0);
      end
      @(posedge clk); #1;
    end
    stop = 1'b0;

    // Backpressure: serializer stalls during PING, then async reset in PONG.
    ser_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int b = 0; b < 19; b++) begin
      ser_ready = (b >= 13);
      @(negedge clk);
      if (b >= 9 && b <= 12) begin
        check("bp_ready", int'(deser_ready), 0);
        check("bp_mode", int'(mem_mode), 2);
        check("bp_rd", int'(rd_en), 0);
      end
      if (b == 13) begin
        check("bp_resume_rd", int'(rd_en), 1);
        check("bp_resume_addr", int'(rd_addr), 0);
      end
      if (b == 17) begin
        check("bp_bubble_mode", int'(mem_mode), 2);
        check("bp_bubble_wr", int'(wr_en), 0);
      end
      if (b == 18) begin
        check("bp_pong_mode", int'(mem_mode), 3);
        check("bp_pong_wr", int'(wr_en), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    // Randomized traffic with occasional mid-cycle asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 15) == 0);
      stop        = ($urandom_range(0, 40) == 0);
      deser_valid = ($urandom_range(0, 3) != 0);
      ser_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rand_rst");
        @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
